// File: rtl/bombman_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bombman_pkg: shared cell/command codes, grid size, FSM states    |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
package bombman_pkg;

  localparam int GRID_ROWS = 10;
  localparam int GRID_COLS = 10;

  localparam logic [1:0] CELL_EMPTY   = 2'd0;
  localparam logic [1:0] CELL_WALL    = 2'd1;
  localparam logic [1:0] CELL_PLAYER1 = 2'd2;
  localparam logic [1:0] CELL_PLAYER2 = 2'd3;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_BOMB  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_CHK    = 3'd2,
    ST_WR_NEW = 3'd3,
    ST_WR_OLD = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arbiter2: two-requester round-robin, last grant resets to p2  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic update,
  input  logic update_p2,
  output logic grant_p2
);

  logic last_p2;

  always_ff @(posedge clk) begin
    if (rst)
      last_p2 <= 1'b1;
    else if (update)
      last_p2 <= update_p2;
  end

  // On a tie the player not served last wins.
  assign grant_p2 = req2 && (!req1 || !last_p2);

endmodule
`default_nettype wire

// File: rtl/arena_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arena_arbiter: serialises player commands onto the grid port     |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module arena_arbiter
  import bombman_pkg::*;
#(
  parameter int ROWS      = GRID_ROWS,
  parameter int COLS      = GRID_COLS,
  parameter int P1_ROW0   = 0,
  parameter int P1_COL0   = 0,
  parameter int P2_ROW0   = 9,
  parameter int P2_COL0   = 9,
  parameter int BOMB_FUSE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_req,
  input  logic [2:0] p1_cmd,
  input  logic       p2_req,
  input  logic [2:0] p2_cmd,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       op_ok,
  output logic [6:0] mem_addr,
  input  logic [1:0] mem_rd_arena,
  input  logic [1:0] mem_rd_bomb,
  output logic       mem_we_arena,
  output logic       mem_we_bomb,
  output logic [1:0] mem_wdata,
  output logic [3:0] p1_row,
  output logic [3:0] p1_col,
  output logic [3:0] p2_row,
  output logic [3:0] p2_col,
  output logic       busy
);

  state_t     state;
  logic       gnt_p2;
  logic       is_bomb;
  logic       tgt_ok;
  logic [3:0] tgt_row;
  logic [3:0] tgt_col;
  logic [6:0] tgt_addr;
  logic [6:0] old_addr;

  logic       grant_p2;
  logic [2:0] sel_cmd;
  logic [3:0] sel_row;
  logic [3:0] sel_col;
  logic [4:0] nxt_row;
  logic [4:0] nxt_col;
  logic       nxt_ok;
  logic [6:0] nxt_addr;
  logic [6:0] sel_addr;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req1      (p1_req),
    .req2      (p2_req),
    .update    (state == ST_DONE),
    .update_p2 (gnt_p2),
    .grant_p2  (grant_p2)
  );

  // Target of the player that would win arbitration this cycle; 5-bit math
  // makes the 0-1 underflow land out of range.
  always_comb begin
    sel_cmd = grant_p2 ? p2_cmd : p1_cmd;
    sel_row = grant_p2 ? p2_row : p1_row;
    sel_col = grant_p2 ? p2_col : p1_col;
    nxt_row = {1'b0, sel_row};
    nxt_col = {1'b0, sel_col};
    nxt_ok  = 1'b1;
    case (sel_cmd)
      CMD_UP:    nxt_row = {1'b0, sel_row} - 5'd1;
      CMD_DOWN:  nxt_row = {1'b0, sel_row} + 5'd1;
      CMD_LEFT:  nxt_col = {1'b0, sel_col} - 5'd1;
      CMD_RIGHT: nxt_col = {1'b0, sel_col} + 5'd1;
      CMD_BOMB:  nxt_ok  = 1'b1;
      default:   nxt_ok  = 1'b0;
    endcase
    if (nxt_row >= 5'(ROWS) || nxt_col >= 5'(COLS))
      nxt_ok = 1'b0;
  end

  assign nxt_addr = 7'(nxt_row) * 7'(COLS) + 7'(nxt_col);
  assign sel_addr = 7'(sel_row) * 7'(COLS) + 7'(sel_col);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      gnt_p2       <= 1'b0;
      is_bomb      <= 1'b0;
      tgt_ok       <= 1'b0;
      tgt_row      <= 4'd0;
      tgt_col      <= 4'd0;
      tgt_addr     <= 7'd0;
      old_addr     <= 7'd0;
      p1_ack       <= 1'b0;
      p2_ack       <= 1'b0;
      op_ok        <= 1'b0;
      mem_addr     <= 7'd0;
      mem_we_arena <= 1'b0;
      mem_we_bomb  <= 1'b0;
      mem_wdata    <= 2'd0;
      p1_row       <= 4'(P1_ROW0);
      p1_col       <= 4'(P1_COL0);
      p2_row       <= 4'(P2_ROW0);
      p2_col       <= 4'(P2_COL0);
    end else begin
      p1_ack       <= 1'b0;
      p2_ack       <= 1'b0;
      op_ok        <= 1'b0;
      mem_addr     <= 7'd0;
      mem_we_arena <= 1'b0;
      mem_we_bomb  <= 1'b0;
      mem_wdata    <= 2'd0;
      case (state)
        ST_IDLE: begin
          if (p1_req || p2_req) begin
            gnt_p2   <= grant_p2;
            is_bomb  <= (sel_cmd == CMD_BOMB);
            tgt_ok   <= nxt_ok;
            tgt_row  <= nxt_row[3:0];
            tgt_col  <= nxt_col[3:0];
            tgt_addr <= nxt_addr;
            old_addr <= sel_addr;
            mem_addr <= nxt_ok ? nxt_addr : 7'd0;
            state    <= ST_RD;
          end
        end
        ST_RD: begin
          if (tgt_ok) begin
            state <= ST_CHK;
          end else begin
            p1_ack <= !gnt_p2;
            p2_ack <= gnt_p2;
            state  <= ST_DONE;
          end
        end
        ST_CHK: begin
          if (is_bomb ? (mem_rd_bomb == 2'd0)
                      : (mem_rd_arena == CELL_EMPTY && mem_rd_bomb == 2'd0)) begin
            mem_addr     <= tgt_addr;
            mem_we_arena <= !is_bomb;
            mem_we_bomb  <= is_bomb;
            mem_wdata    <= is_bomb ? 2'(BOMB_FUSE)
                                    : (gnt_p2 ? CELL_PLAYER2 : CELL_PLAYER1);
            state        <= ST_WR_NEW;
          end else begin
            p1_ack <= !gnt_p2;
            p2_ack <= gnt_p2;
            state  <= ST_DONE;
          end
        end
        ST_WR_NEW: begin
          if (is_bomb) begin
            p1_ack <= !gnt_p2;
            p2_ack <= gnt_p2;
            op_ok  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            mem_addr     <= old_addr;
            mem_we_arena <= 1'b1;
            mem_wdata    <= CELL_EMPTY;
            state        <= ST_WR_OLD;
          end
        end
        ST_WR_OLD: begin
          if (gnt_p2) begin
            p2_row <= tgt_row;
            p2_col <= tgt_col;
          end else begin
            p1_row <= tgt_row;
            p1_col <= tgt_col;
          end
          p1_ack <= !gnt_p2;
          p2_ack <= gnt_p2;
          op_ok  <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arena_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_arena_arbiter: directed checks of moves, bombs, arbitration   |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_arena_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p1_req, p2_req;
  logic [2:0] p1_cmd, p2_cmd;
  logic       p1_ack, p2_ack, op_ok;
  logic [6:0] mem_addr;
  logic [1:0] mem_rd_arena, mem_rd_bomb;
  logic       mem_we_arena, mem_we_bomb;
  logic [1:0] mem_wdata;
  logic [3:0] p1_row, p1_col, p2_row, p2_col;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Grid memory model with a poke/clear port for directed setup.
  logic [1:0] arena_m [0:127];
  logic [1:0] bomb_m  [0:127];
  logic       poke_en = 1'b0;
  logic       clr     = 1'b0;
  logic [6:0] poke_addr = 7'd0;
  logic [1:0] poke_arena = 2'd0;
  logic [1:0] poke_bomb  = 2'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_arena <= arena_m[mem_addr];
    mem_rd_bomb  <= bomb_m[mem_addr];
    if (clr) begin
      for (int i = 0; i < 128; i++) begin
        arena_m[i] <= 2'd0;
        bomb_m[i]  <= 2'd0;
      end
    end else if (poke_en) begin
      arena_m[poke_addr] <= poke_arena;
      bomb_m[poke_addr]  <= poke_bomb;
    end else begin
      if (mem_we_arena) arena_m[mem_addr] <= mem_wdata;
      if (mem_we_bomb)  bomb_m[mem_addr]  <= mem_wdata;
    end
  end

  arena_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .p1_req       (p1_req),
    .p1_cmd       (p1_cmd),
    .p2_req       (p2_req),
    .p2_cmd       (p2_cmd),
    .p1_ack       (p1_ack),
    .p2_ack       (p2_ack),
    .op_ok        (op_ok),
    .mem_addr     (mem_addr),
    .mem_rd_arena (mem_rd_arena),
    .mem_rd_bomb  (mem_rd_bomb),
    .mem_we_arena (mem_we_arena),
    .mem_we_bomb  (mem_we_bomb),
    .mem_wdata    (mem_wdata),
    .p1_row       (p1_row),
    .p1_col       (p1_col),
    .p2_row       (p2_row),
    .p2_col       (p2_col),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic poke(input logic [6:0] a, input logic [1:0] ar, input logic [1:0] bm);
    poke_addr  = a;
    poke_arena = ar;
    poke_bomb  = bm;
    poke_en    = 1'b1;
    step();
    poke_en    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b1;
    p1_req = 1'b0; p2_req = 1'b0; p1_cmd = 3'd0; p2_cmd = 3'd0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_acks", {p1_ack, p2_ack, op_ok}, 0);
    chk("rst_strobes", {mem_we_arena, mem_we_bomb}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_p1pos", {p1_row, p1_col}, 8'h00);
    chk("rst_p2pos", {p2_row, p2_col}, 8'h99);
    rst = 1'b0; clr = 1'b0;

    // p1 UP at (0,0): out of bounds
    p1_cmd = 3'd1; p1_req = 1'b1;
    step(); chk("oob_rd_addr", mem_addr, 0); chk("oob_busy", busy, 1);
    step(); chk("oob_ack", p1_ack, 1); chk("oob_ok", op_ok, 0);
    chk("oob_strobes", {mem_we_arena, mem_we_bomb}, 0);
    chk("oob_pos", {p1_row, p1_col}, 8'h00);
    p1_req = 1'b0; step();

    // command 6 behaves as NOP
    p1_cmd = 3'd6; p1_req = 1'b1;
    step(); step(); chk("nop_ack", p1_ack, 1); chk("nop_ok", op_ok, 0);
    p1_req = 1'b0; step();

    // p1 RIGHT (0,0)->(0,1)
    p1_cmd = 3'd4; p1_req = 1'b1;
    step(); chk("right_rd_addr", mem_addr, 1);
    step(); chk("right_chk_we", mem_we_arena, 0); chk("right_chk_ack", p1_ack, 0);
    step(); chk("right_new_we", {mem_we_arena, mem_we_bomb}, 2'b10);
    chk("right_new_addr", mem_addr, 1); chk("right_new_data", mem_wdata, 2);
    step(); chk("right_old_we", mem_we_arena, 1);
    chk("right_old_addr", mem_addr, 0); chk("right_old_data", mem_wdata, 0);
    step(); chk("right_ack", p1_ack, 1); chk("right_ok", op_ok, 1);
    chk("right_pos", {p1_row, p1_col}, 8'h01);
    p1_req = 1'b0; step();
    chk("idle_after_right", busy, 0);

    // p2 LEFT into a wall at addr 98
    poke(7'd98, 2'd1, 2'd0);
    p2_cmd = 3'd3; p2_req = 1'b1;
    step(); chk("wall_rd_addr", mem_addr, 98);
    step(); chk("wall_chk_ack", p2_ack, 0);
    step(); chk("wall_ack", p2_ack, 1); chk("wall_ok", op_ok, 0);
    chk("wall_p1ack", p1_ack, 0);
    chk("wall_strobes", {mem_we_arena, mem_we_bomb}, 0);
    chk("wall_pos", {p2_row, p2_col}, 8'h99);
    p2_req = 1'b0; step();

    // p2 LEFT into a bomb cell
    poke(7'd98, 2'd0, 2'd2);
    p2_req = 1'b1;
    step(); step();
    step(); chk("bombcell_ack", p2_ack, 1); chk("bombcell_ok", op_ok, 0);
    chk("bombcell_strobes", {mem_we_arena, mem_we_bomb}, 0);
    chk("bombcell_pos", {p2_row, p2_col}, 8'h99);
    p2_req = 1'b0; step();

    // p2 BOMB at (9,9)
    p2_cmd = 3'd5; p2_req = 1'b1;
    step(); chk("bomb_rd_addr", mem_addr, 99);
    step();
    step(); chk("bomb_we", {mem_we_arena, mem_we_bomb}, 2'b01);
    chk("bomb_addr", mem_addr, 99); chk("bomb_data", mem_wdata, 3);
    step(); chk("bomb_ack", p2_ack, 1); chk("bomb_ok", op_ok, 1);
    p2_req = 1'b0; step();

    // second bomb on the same cell is refused
    p2_req = 1'b1;
    step(); step();
    step(); chk("rebomb_ack", p2_ack, 1); chk("rebomb_ok", op_ok, 0);
    chk("rebomb_we", mem_we_bomb, 0);
    p2_req = 1'b0; step();

    // arbitration from reset: tie goes to p1
    rst = 1'b1; clr = 1'b1; step(); rst = 1'b0; clr = 1'b0;
    p1_cmd = 3'd4; p2_cmd = 3'd1; p1_req = 1'b1; p2_req = 1'b1;
    step(); chk("tie1_addr", mem_addr, 1);
    repeat (4) step();
    chk("tie1_p1ack", p1_ack, 1); chk("tie1_p2ack", p2_ack, 0); chk("tie1_ok", op_ok, 1);
    p1_req = 1'b0;
    step(); chk("tie1_gap_busy", busy, 0);
    step(); chk("tie1_p2_rd", busy, 1); chk("tie1_p2_addr", mem_addr, 89);
    step();
    step(); chk("tie1_p2_new", {mem_we_arena, mem_addr, mem_wdata}, {1'b1, 7'd89, 2'd3});
    step(); chk("tie1_p2_old", {mem_we_arena, mem_addr, mem_wdata}, {1'b1, 7'd99, 2'd0});
    step(); chk("tie1_p2ack", p2_ack, 1); chk("tie1_p2pos", {p2_row, p2_col}, 8'h89);
    p2_req = 1'b0; step();

    // tie again: p1 still wins
    p1_cmd = 3'd3; p2_cmd = 3'd2; p1_req = 1'b1; p2_req = 1'b1;
    step(); chk("tie2_addr", mem_addr, 0);
    repeat (4) step();
    chk("tie2_p1ack", p1_ack, 1); chk("tie2_p1pos", {p1_row, p1_col}, 8'h00);
    p1_req = 1'b0;
    repeat (6) step();
    chk("tie2_p2ack", p2_ack, 1); chk("tie2_p2pos", {p2_row, p2_col}, 8'h99);
    p2_req = 1'b0; step();

    // p2 alone, then a tie: p1 wins
    p2_cmd = 3'd1; p2_req = 1'b1;
    step(); chk("p2solo_addr", mem_addr, 89);
    repeat (4) step(); chk("p2solo_ack", p2_ack, 1);
    p2_req = 1'b0; step();
    p1_cmd = 3'd4; p2_cmd = 3'd0; p1_req = 1'b1; p2_req = 1'b1;
    step(); chk("tie3_addr", mem_addr, 1);
    repeat (4) step(); chk("tie3_p1ack", p1_ack, 1); chk("tie3_p1pos", {p1_row, p1_col}, 8'h01);
    p1_req = 1'b0;
    step(); step(); chk("tie3_nop_addr", mem_addr, 0);
    step(); chk("tie3_p2ack", p2_ack, 1); chk("tie3_p2ok", op_ok, 0);
    p2_req = 1'b0; step();

    // p1 alone, then a tie: p2 wins
    p1_cmd = 3'd0; p1_req = 1'b1;
    step(); step(); chk("p1solo_ack", p1_ack, 1);
    p1_req = 1'b0; step();
    p1_req = 1'b1; p2_req = 1'b1;
    step(); step(); chk("tie4_p2ack", p2_ack, 1); chk("tie4_p1ack", p1_ack, 0);
    p2_req = 1'b0;
    step(); step(); step(); chk("tie4_p1late", p1_ack, 1);
    p1_req = 1'b0; step();

    // reset during WR_NEW of a p1 move (0,1)->(0,2)
    p1_cmd = 3'd4; p1_req = 1'b1;
    repeat (3) step();
    chk("rmid_new", {mem_we_arena, mem_addr}, {1'b1, 7'd2});
    rst = 1'b1; p1_req = 1'b0;
    step();
    chk("rmid_strobes", {mem_we_arena, mem_we_bomb}, 0);
    chk("rmid_acks", {p1_ack, p2_ack}, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_addr", mem_addr, 0);
    chk("rmid_p1pos", {p1_row, p1_col}, 8'h00);
    chk("rmid_p2pos", {p2_row, p2_col}, 8'h99);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arena_arbiter.md
# arena_arbiter

Sequencer and arbiter that owns the single shared access port of the 10x10 arena/bomb grid memory and serialises player commands onto it. Player 1 (buttons) and player 2 (keypad decoder) each raise a request with a command. The block grants one at a time round-robin, runs a read-check-write sequence against the grid, and tracks both player positions in registers. It sits between the input decoders and the grid memory; the display reads the grid directly.

## Interface
Parameters:
- ROWS, 10, grid rows
- COLS, 10, grid columns
- P1_ROW0 / P1_COL0, 0 / 0, player 1 start cell
- P2_ROW0 / P2_COL0, 9 / 9, player 2 start cell
- BOMB_FUSE, 3, value written into a bomb cell on placement

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- p1_req / p2_req  in  1  command request; held high until the matching ack
- p1_cmd / p2_cmd  in  3  0 NOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 BOMB; 6–7 are treated as NOP
- p1_ack / p2_ack  out  1  one-cycle completion pulse
- op_ok  out  1  valid with ack; 1 means the move or bomb was applied
- mem_addr  out  7  row*COLS+col
- mem_rd_arena  in  2  arena cell; 0 empty, 1 wall, 2 player 1, 3 player 2; 1-cycle synchronous read
- mem_rd_bomb  in  2  bomb cell; 0 means none
- mem_we_arena / mem_we_bomb  out  1  write strobes
- mem_wdata  out  2  write data
- p1_row, p1_col, p2_row, p2_col  out  4  current positions
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, RD, CHK, WR_NEW, WR_OLD, DONE.
- IDLE:
  - If any request is pending, arbitrate, then latch the granted player, its command and its current position. Go to RD.
  - Arbitration: when only one player requests, that player wins. When both request, the player not granted last wins. last_grant resets to player 2, so player 1 wins the first tie.
- RD:
  - Compute the target cell: UP is row−1, DOWN is row+1, LEFT is col−1, RIGHT is col+1, BOMB is the player's own cell.
  - NOP, or a target outside 0..ROWS−1 / 0..COLS−1 (including the 0−1 underflow), goes to DONE with ok=0 and no memory read.
  - Otherwise drive mem_addr = target and go to CHK.
- CHK (read data valid this cycle):
  - Move: if arena==0 and bomb==0, go to WR_NEW; else go to DONE with ok=0. A cell holding the other player counts as blocked.
  - BOMB: if bomb==0, go to WR_NEW; else go to DONE with ok=0.
- WR_NEW:
  - Move: mem_we_arena=1 at the target, wdata = 2 or 3 (the player code); go to WR_OLD.
  - BOMB: mem_we_bomb=1 at the own cell, wdata=BOMB_FUSE; go to DONE with ok=1.
- WR_OLD: mem_we_arena=1 at the old cell, wdata=0. The position register takes the target at the end of this cycle. Go to DONE with ok=1.
- DONE: the granted player's ack=1 and op_ok is valid; update last_grant; go to IDLE.
- Requests are sampled only in IDLE.
  - A request dropped mid-operation does not abort it; ack still pulses.
  - A request still high in the cycle after ack starts a new operation.
- At most one write strobe is high per cycle. mem_addr, mem_wdata and the strobes are 0 outside RD/WR_NEW/WR_OLD.
- This block never initialises grid contents; the memory owner does.

## Timing
Request first seen in IDLE at cycle T.

Latencies:
- Successful move: writes at T+3 and T+4, ack at T+5.
- Successful bomb: write at T+3, ack at T+4.
- Out-of-bounds or NOP: ack at T+2.
- Blocked cell: ack at T+3.
- A pending second requester enters RD one cycle after the first requester's ack (IDLE cycle between operations).

Position outputs:
- A new position is visible in the DONE cycle.
- They are unchanged on failure.

Reset values:
- State IDLE; all acks, op_ok, strobes, mem_addr, mem_wdata and busy are 0.
- Positions are the P*_ROW0/COL0 values; last_grant is player 2.

Reset mid-operation:
- No write strobe in the cycle after rst is sampled, and no ack.
- Positions return to their start values; any half-completed move (WR_NEW done, WR_OLD not) is left in memory.

## Structure
- Shared package bombman_pkg holds:
  - cell codes (EMPTY, WALL, PLAYER1, PLAYER2)
  - command codes
  - ROWS/COLS defaults
  - the FSM state enum
- Sub-module rr_arbiter2 is a two-requester round-robin with a last_grant register and an update strobe driven in DONE.
- Target computation and bounds checking stay inline.

## Test plan
- Right move: after reset, p1_req with RIGHT (1 at (0,0), empty cells).
  - Required: we_arena addr 1 data 2 at T+3; we_arena addr 0 data 0 at T+4.
  - Then p1_ack=1, op_ok=1, p1_col=1 at T+5.
- Out-of-bounds: p1 UP at (0,0).
  - Required: p1_ack with op_ok=0 at T+2.
  - No strobes; position stays (0,0).
- Blocked by wall: p2 LEFT at (9,9) with mem returning arena=1 for addr 98.
  - Required: ack with op_ok=0 at T+3; no writes.
  - Repeat with arena=0, bomb=2: same result.
- Bomb placement: p2 BOMB at (9,9), bomb=0.
  - Required: we_bomb addr 99 data 3 at T+3; ack with op_ok=1 at T+4.
  - Repeat with bomb=3: op_ok=0 at T+3.
- Arbitration: p1 and p2 request together from reset, both held until acked.
  - Required: p1 served first, p2 RD starts one cycle after p1_ack.
  - Both requesting again: p1 first again (last_grant=p2).
  - p2 alone, then a tie: p1 wins.
- Reset mid-operation: assert rst while in WR_NEW of a p1 move.
  - Required: next cycle IDLE, no strobes, no ack.
  - Positions (0,0)/(9,9); busy=0.
